// File: rtl/bft_leaf_interface.sv
// bft_leaf_interface: bridges one processing element (PE) to a leaf of a
// butterfly fat tree. PE words are queued in a send FIFO and driven into the
// tree through a registered output stage that holds a packet while the tree
// asks for a resend. Packets from the tree are captured into a receive FIFO
// that the PE drains with a valid/ready handshake.
//
// Optional feature: define BFT_LEAF_STATS_EN to add the stat_sent,
// stat_resent and stat_dropped 16-bit saturating counters.
module bft_leaf_interface #(
    parameter int payload_sz = 43,
    parameter int p_sz       = 49,
    parameter int addr_sz    = 5,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [payload_sz-1:0] pe_din,
    input  logic [addr_sz-1:0]    pe_dest,
    input  logic                  pe_din_valid,
    output logic                  pe_din_ready,
    output logic [p_sz-1:0]       to_tree,
    input  logic                  resend,
    input  logic [p_sz-1:0]       from_tree,
    output logic [payload_sz-1:0] pe_dout,
    output logic                  pe_dout_valid,
    input  logic                  pe_dout_ready
`ifdef BFT_LEAF_STATS_EN
    ,
    output logic [15:0]           stat_sent,
    output logic [15:0]           stat_resent,
    output logic [15:0]           stat_dropped
`endif
);

    // Pointers carry one extra wrap bit so a full FIFO and an empty FIFO
    // can be told apart without sacrificing an entry.
    localparam int ptr_w = $clog2(fifo_depth);
    typedef logic [ptr_w:0] ptr_t;

    typedef enum logic {
        IDLE,
        PEND
    } out_state_t;

    // ------------------------------------------------------------------
    // Send path: PE -> send FIFO -> output register -> tree
    // ------------------------------------------------------------------
    logic [p_sz-2:0] send_mem [fifo_depth];
    ptr_t            send_wr;
    ptr_t            send_rd;
    logic            send_empty;
    logic            send_full;
    logic            send_push;
    logic            send_pop;
    logic            ready_en;
    out_state_t      out_state;

    assign send_empty = (send_wr == send_rd);
    assign send_full  = (send_wr[ptr_w] != send_rd[ptr_w]) &&
                        (send_wr[ptr_w-1:0] == send_rd[ptr_w-1:0]);

    // ready_en keeps pe_din_ready low through reset and lets it rise on the
    // first cycle after release; both terms are registered state only.
    assign pe_din_ready = ready_en && !send_full;
    assign send_push    = pe_din_valid && pe_din_ready;

    // A word leaves the FIFO whenever the output register is free: it is idle,
    // or the packet it holds is being accepted this cycle (resend low).
    assign send_pop = !send_empty && ((out_state == IDLE) || !resend);

    // Send FIFO storage: written on every accepted PE word.
    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (send_push) begin
            send_mem[send_wr[ptr_w-1:0]] <= {pe_dest, pe_din};
        end
    end

    // Send FIFO pointers and the post-reset ready enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            send_wr  <= '0;
            send_rd  <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (send_push) send_wr <= send_wr + ptr_t'(1);
            if (send_pop)  send_rd <= send_rd + ptr_t'(1);
        end
    end

    // Output stage: load the FIFO head, hold it on resend, or fall idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_state <= IDLE;
            to_tree   <= '0;
        end else begin
            if ((out_state == PEND) && resend) begin
                out_state <= PEND;
                to_tree   <= to_tree;
            end else if (send_pop) begin
                out_state <= PEND;
                to_tree   <= {1'b1, send_mem[send_rd[ptr_w-1:0]]};
            end else begin
                out_state <= IDLE;
                to_tree   <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive path: tree -> receive FIFO -> PE
    // ------------------------------------------------------------------
    logic [payload_sz-1:0] rx_mem [fifo_depth];
    ptr_t                  rx_wr;
    ptr_t                  rx_rd;
    logic                  rx_empty;
    logic                  rx_full;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_in_valid;
    logic                  dest_unused;

    // The destination field has already been resolved by the tree; only the
    // payload is kept at the leaf.
    assign dest_unused = ^from_tree[p_sz-2:payload_sz];

    assign rx_in_valid   = from_tree[p_sz-1];
    assign rx_empty      = (rx_wr == rx_rd);
    assign rx_full       = (rx_wr[ptr_w] != rx_rd[ptr_w]) &&
                           (rx_wr[ptr_w-1:0] == rx_rd[ptr_w-1:0]);
    assign rx_pop        = !rx_empty && pe_dout_ready;
    // The tree cannot be stalled: a packet that finds no room is lost, but a
    // pop in the same cycle frees the slot it needs.
    assign rx_push       = rx_in_valid && (!rx_full || rx_pop);
    assign pe_dout_valid = !rx_empty;
    assign pe_dout       = rx_empty ? '0 : rx_mem[rx_rd[ptr_w-1:0]];

    // Receive FIFO storage: captures the payload of each stored tree packet.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr[ptr_w-1:0]] <= from_tree[payload_sz-1:0];
        end
    end

    // Receive FIFO pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + ptr_t'(1);
            if (rx_pop)  rx_rd <= rx_rd + ptr_t'(1);
        end
    end

`ifdef BFT_LEAF_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic sent_evt;
    logic resent_evt;
    logic drop_evt;

    assign sent_evt   = (out_state == PEND) && !resend;
    assign resent_evt = (out_state == PEND) && resend;
    assign drop_evt   = rx_in_valid && !rx_push;

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_sent    <= '0;
            stat_resent  <= '0;
            stat_dropped <= '0;
        end else begin
            if (sent_evt && (stat_sent != 16'hFFFF))
                stat_sent <= stat_sent + 16'd1;
            if (resent_evt && (stat_resent != 16'hFFFF))
                stat_resent <= stat_resent + 16'd1;
            if (drop_evt && (stat_dropped != 16'hFFFF))
                stat_dropped <= stat_dropped + 16'd1;
        end
    end
`endif

endmodule

// File: doc/bft_leaf_interface.md
BFT_LEAF_INTERFACE -- requirements
Module: bft_leaf_interface

Interface
REQ-001 SHALL have parameter payload_sz, default 43: PE payload width in bits.
REQ-002 SHALL have parameter p_sz, default 49: tree packet width, laid out {valid[p_sz-1], dest[p_sz-2:payload_sz], payload[payload_sz-1:0]}.
REQ-003 SHALL have parameter addr_sz, default 5: dest width; legal only when p_sz == payload_sz+addr_sz+1.
REQ-004 SHALL have parameter fifo_depth, default 4: entries per direction; power of two, at least 2.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 pe_din  input  payload_sz  payload from the PE.
REQ-008 pe_dest  input  addr_sz  destination leaf address for pe_din.
REQ-009 pe_din_valid  input  1  PE offers a word.
REQ-010 pe_din_ready  output  1  word accepted when valid and ready are both high.
REQ-011 to_tree  output  p_sz  packet driven into the subtree leaf input.
REQ-012 resend  input  1  tree rejected the packet on to_tree this cycle.
REQ-013 from_tree  input  p_sz  packet from the subtree leaf output; bit p_sz-1 is valid.
REQ-014 pe_dout  output  payload_sz  payload delivered to the PE.
REQ-015 pe_dout_valid  output  1  pe_dout holds a word.
REQ-016 pe_dout_ready  input  1  PE consumes the word when valid and ready are both high.

Function
REQ-017 SHALL buffer PE words in a send FIFO of fifo_depth entries; pe_din_ready = send FIFO not full.
- pe_din_ready is registered-state based, with no combinational path from pe_din_valid.
REQ-018 SHALL drive to_tree from a register.
- Output-stage states: IDLE (to_tree all zero) and PEND (valid bit 1).
REQ-019 IDLE -> PEND SHALL occur on the cycle the send FIFO is non-empty; the head word is popped and loaded into to_tree the next cycle.
REQ-020 In PEND with resend=0, the packet SHALL count as accepted.
- Next cycle loads the next FIFO word (stay PEND), or clears to IDLE if the FIFO is empty.
- Gives back-to-back throughput of one packet per cycle.
REQ-021 In PEND with resend=1, to_tree SHALL hold the identical packet the next cycle; no pop.
REQ-022 resend while IDLE SHALL be ignored.
REQ-023 A push and a pop in the same cycle on a full send FIFO SHALL both succeed, with the count unchanged.
REQ-024 SHALL capture from_tree into a receive FIFO of fifo_depth entries when from_tree[p_sz-1]=1.
- Only the payload field is stored.
- Capture latency to pe_dout_valid is exactly 1 cycle when the FIFO was empty.
REQ-025 from_tree cannot be backpressured. A valid packet arriving while the receive FIFO is full, with no simultaneous pop, SHALL be dropped.
- A simultaneous pop makes room, so the packet is stored.
REQ-026 pe_dout/pe_dout_valid SHALL present the receive FIFO head; pe_dout_valid = receive FIFO not empty.
REQ-027 Pointers SHALL wrap modulo fifo_depth; full/empty SHALL use an extra wrap bit, giving no lost entry.

Reset
REQ-028 While reset=0 at a clock edge:
- both FIFOs SHALL empty;
- the output stage SHALL go IDLE;
- to_tree=0, pe_din_ready=0, pe_dout_valid=0, pe_dout=0.
REQ-029 pe_din_ready SHALL rise the first cycle after reset deasserts.
REQ-030 Reset mid-operation SHALL discard all buffered and pending packets without emitting partial ones.

Configuration
REQ-031 Macro BFT_LEAF_STATS_EN compiled in SHALL add these 16-bit saturating counters, each cleared by reset:
- output stat_sent: accepted tree packets;
- output stat_resent: cycles with resend=1 in PEND;
- output stat_dropped: receive-FIFO drops.
REQ-032 Without BFT_LEAF_STATS_EN, these ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-033 Reset then idle: after reset=0 for 2 cycles, release -> to_tree=0, pe_dout_valid=0, pe_din_ready=1 on the next cycle.
REQ-034 Push payload 0x123, dest 5, resend=0 -> to_tree = {1'b1, 5'd5, 43'h123} for exactly one cycle, then 0.
REQ-035 Push 3 words, resend=1 for 2 cycles on the first -> first packet is held 3 cycles total, all three emerge in order, stat_sent=3, stat_resent=2.
REQ-036 Push 6 words with resend held at 1 -> pe_din_ready=0 after 5 accepted words (4 in FIFO plus 1 pending); release resend -> all 6 arrive in order.
REQ-037 Send 5 valid from_tree packets on consecutive cycles with pe_dout_ready=0 -> the first 4 are retained in order and the 5th is dropped (stat_dropped=1); raise ready -> 4 words delivered.
REQ-038 With from_tree valid and pe_dout_ready=1 at full receive FIFO in the same cycle -> no drop, occupancy stays 4.
